// File: rtl/mult_hilo.sv
// mult_hilo: HI/LO commit stage behind the fixed-latency 32x32 multiplier.
// It tracks an issued multiply for LATENCY edges. On the final edge it
// captures the 64-bit product z into {hi,lo}, as a plain write or as an
// accumulate. It also services MTHI/MTLO moves while no multiply is in flight.
// Optional feature macro: MULT_HILO_ACC_EN.
//   Defined   - op 01 adds z to {hi,lo}, and op 10 subtracts z from {hi,lo}.
//   Undefined - every op value writes z.
module mult_hilo #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] z,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic [63:0] commit_d;

`ifdef MULT_HILO_ACC_EN
    // Commit value: write, or 64-bit modulo add/subtract against current {hi,lo}
    always_comb begin
        commit_d = z;
        case (op_q)
            2'b01:   commit_d = {hi_q, lo_q} + z;
            2'b10:   commit_d = {hi_q, lo_q} - z;
            default: commit_d = z;
        endcase
    end
`else
    // Without the accumulate datapath, every op commits as a plain write
    assign commit_d = z;

    // op is still latched with start so both builds track the same state.
    // In this build nothing reads it.
    logic unused_op;
    assign unused_op = ^op_q;
`endif

    // Control FSM, iteration counter and HI/LO architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'b00;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Issue wins over any simultaneous move
                        op_q    <= op;
                        cnt_q   <= LAT_LOAD;
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        if (mthi) begin
                            hi_q <= wdata;
                        end
                        if (mtlo) begin
                            lo_q <= wdata;
                        end
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // start/mthi/mtlo are ignored while a multiply is in flight
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        {hi_q, lo_q} <= commit_d;
                        state_q      <= ST_DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_hilo.sv
// Directed testbench for mult_hilo: table of multiplies plus hand-written
// sequences for ignored inputs, issue-vs-move priority, back-to-back issue
// and mid-flight reset. Expected values follow the MULT_HILO_ACC_EN build mode.
module tb_mult_hilo;

    localparam int unsigned LAT = 4;
`ifdef MULT_HILO_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [63:0] z;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    mult_hilo #(.LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .z     (z),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] z;
        logic [63:0] exp_acc;
        logic [63:0] exp_wr;
        string       name;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end else begin
            $display("ok   %s value=%h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply from IDLE and follow it through to IDLE again
    task automatic run_mult(input logic [1:0] o, input logic [63:0] zz,
                            input logic [63:0] exp, input string nm);
        start = 1'b1;
        op    = o;
        z     = zz;
        tick();                              // E0
        start = 1'b0;
        check({nm, " busy@E0"}, 64'(busy), 64'd1);
        for (int i = 1; i < int'(LAT); i++) begin
            tick();
            check({nm, " busy wait"}, 64'(busy), 64'd1);
        end
        tick();                              // E0+LAT: commit
        check({nm, " busy fall"}, 64'(busy), 64'd0);
        check({nm, " done"}, 64'(done), 64'd1);
        check({nm, " hilo"}, {hi, lo}, exp);
        tick();
        check({nm, " done drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_cnt;
        logic [63:0] exp_v;

        vecs[0] = '{2'b00, 64'h0000_0000_0000_0019, 64'h0000_0000_0000_0019, 64'h0000_0000_0000_0019, "v0 wr -5*-5"};
        vecs[1] = '{2'b01, 64'd50,                  64'h0000_0000_0000_004B, 64'h0000_0000_0000_0032, "v1 add 50"};
        vecs[2] = '{2'b10, 64'h0000_0000_0000_004C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_004C, "v2 sub wrap"};
        vecs[3] = '{2'b11, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_0002, "v3 op11 wr"};
        vecs[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, "v4 add carry"};
        vecs[5] = '{2'b10, 64'h0000_0002_0000_0000, 64'hFFFF_FFFF_0000_0001, 64'h0000_0002_0000_0000, "v5 sub borrow"};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        z     = 64'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        // Table-driven multiplies, each one chaining on the previous result
        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].op, vecs[i].z, ACC ? vecs[i].exp_acc : vecs[i].exp_wr, vecs[i].name);
        end

        // start and mthi during WAIT are both ignored
        start = 1'b1;
        op    = 2'b00;
        z     = 64'h0000_0000_0000_0055;
        tick();                              // E0
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        mthi  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();                              // E0+3, inside WAIT
        start = 1'b0;
        mthi  = 1'b0;
        check("ign busy E0+3", 64'(busy), 64'd1);
        check("ign hi E0+3", 64'(hi), ACC ? 64'hFFFF_FFFF : 64'h0000_0002);
        tick();                              // E0+4
        check("ign done", 64'(done), 64'd1);
        check("ign hilo", {hi, lo}, 64'h0000_0000_0000_0055);
        tick();
        check("ign no reissue busy", 64'(busy), 64'd0);
        check("ign done drop", 64'(done), 64'd0);

        // Moves in IDLE: both halves together
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h1234_5678;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("move both", {hi, lo}, 64'h1234_5678_1234_5678);
        check("move busy", 64'(busy), 64'd0);

        // Move together with start: start wins, move dropped
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        mthi  = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        z     = 64'h0000_0001_0000_0002;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("prio move dropped", {hi, lo}, 64'h1234_5678_1234_5678);
        check("prio busy", 64'(busy), 64'd1);
        for (int i = 1; i < int'(LAT); i++) tick();
        tick();
        check("prio done", 64'(done), 64'd1);
        check("prio hilo", {hi, lo}, 64'h0000_0001_0000_0002);
        tick();

        // Back-to-back issue from DONE, starting from zero
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'd0;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("b2b clear", {hi, lo}, 64'd0);
        done_cnt = 0;
        start = 1'b1;
        op    = 2'b01;
        z     = 64'd50;
        tick();                              // E0
        start = 1'b0;
        for (int i = 1; i < int'(LAT); i++) tick();
        tick();                              // first commit, DONE cycle
        if (done) done_cnt++;
        check("b2b first hilo", {hi, lo}, ACC ? 64'd50 : 64'd50);
        start = 1'b1;                        // issue in DONE
        tick();
        start = 1'b0;
        check("b2b busy no gap", 64'(busy), 64'd1);
        for (int i = 1; i < int'(LAT); i++) begin
            tick();
            if (done) done_cnt++;
        end
        tick();
        if (done) done_cnt++;
        exp_v = ACC ? 64'd100 : 64'd50;
        check("b2b final hilo", {hi, lo}, exp_v);
        tick();
        if (done) done_cnt++;
        check("b2b done pulses", 64'(done_cnt), 64'd2);

        // Reset one cycle before the commit edge abandons the multiply
        start = 1'b1;
        op    = 2'b00;
        z     = 64'h0000_0000_0000_0077;
        tick();                              // E0
        start = 1'b0;
        for (int i = 1; i < int'(LAT) - 1; i++) tick();
        reset = 1'b1;
        tick();                              // E0+LAT-1 sampled with reset
        reset = 1'b0;
        check("rst hilo", {hi, lo}, 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        tick();                              // would-be commit edge
        check("rst no commit hilo", {hi, lo}, 64'd0);
        check("rst no commit done", 64'(done), 64'd0);
        run_mult(2'b00, 64'h0000_0000_0000_0019, 64'h0000_0000_0000_0019, "post-rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_hilo.md
# mult_hilo

Downstream stage of the 32×32 multiplier (MULT). It tracks an issued multiply through the multiplier's fixed latency, captures the 64-bit product `z`, and commits it into architectural HI/LO registers. Commit is either a plain write or an optional accumulate/subtract. It also services direct HI/LO writes (MTHI/MTLO) and exposes `busy`/`done` so the issuing pipeline can stall and read results.

## Interface
Parameters:
- `LATENCY`, default 4: rising edges from the `start` sample to a valid `z`. Legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue a multiply. Sampled only in IDLE or DONE.
- `op` in 2: commit mode, latched with `start`. `00` = write, `01` = accumulate add, `10` = accumulate subtract, `11` = write.
- `z` in 64: product from MULT; sampled only on the commit edge.
- `mthi` in 1: write `wdata` to HI.
- `mtlo` in 1: write `wdata` to LO.
- `wdata` in 32: data for `mthi`/`mtlo`.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: multiply in flight.
- `done` out 1: one-cycle pulse after a commit.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - WAIT: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE or DONE with `start`=1: latch `op`, load counter with `LATENCY`, go to WAIT.
  - WAIT: decrement counter each edge. On the edge where the counter reaches 0, commit and go to DONE.
  - DONE with `start`=0: go to IDLE.
- Commit arithmetic: `acc = {hi,lo}`.
  - `op` write: `{hi,lo} <= z`.
  - `op` 01: `{hi,lo} <= acc + z`.
  - `op` 10: `{hi,lo} <= acc - z`.
  - All 64-bit modulo 2^64; carry/borrow out is discarded with no flag.
- `z` is treated as an opaque 64-bit pattern; signedness is MULT's concern.
- MTHI/MTLO:
  - Accepted only in IDLE or DONE with `start`=0.
  - Writes the addressed half on that edge; both may assert together.
- Boundary rules:
  - `start` during WAIT is ignored. No queueing; the issuer must watch `busy`.
  - `mthi`/`mtlo` during WAIT is ignored.
  - `start` together with `mthi`/`mtlo` in IDLE/DONE: `start` wins and the move is dropped.
  - Back-to-back issue: `start` in DONE re-enters WAIT directly, with `done`=1 for that cycle. The accumulate source is the just-committed value.
  - `reset` mid-operation: abandons the in-flight multiply with no commit. Next cycle: IDLE, `hi`=0, `lo`=0.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.

## Timing
- Edge E0 samples `start`=1: `busy`=1 from E0 until edge E0+LATENCY.
- At E0+LATENCY:
  - `z` is sampled.
  - `hi`/`lo` update and are visible in the following cycle.
  - `busy` falls.
  - `done`=1 for exactly the cycle after E0+LATENCY.
- Minimum issue-to-issue interval: LATENCY+1 edges, i.e. `start` asserted in DONE.
- MTHI/MTLO: one-edge latency; new value is visible in the next cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `MULT_HILO_ACC_EN` defined:
  - `op` 01 and 10 perform accumulate add/subtract as specified.
  - Adds one 64-bit add/sub datapath.
- `MULT_HILO_ACC_EN` undefined:
  - Every `op` value behaves as write (`{hi,lo} <= z`).
  - No adder is synthesized; `op` is still latched but only 00 semantics apply.

## Test plan
1. Reset, then `start`, `op`=00, `z`=64'h0000_0000_0000_0019 (-5 × -5), LATENCY=4 -> `busy` high for 4 cycles; `hi`=0, `lo`=32'h19; `done` pulses once.
2. After (1), `start`, `op`=01, `z`=64'd50 (10 × 5) -> `{hi,lo}`=64'h4B. Then `op`=10, `z`=64'h4C -> `{hi,lo}`=64'hFFFF_FFFF_FFFF_FFFF (wrap, no flag). With the macro undefined, the same sequence yields 64'h32 then 64'h4C.
3. `start` pulsed again 2 cycles into WAIT, plus `mthi`=1 with `wdata`=32'hDEAD_BEEF -> both ignored; a single commit occurs at E0+4 and `hi` is not DEADBEEF.
4. In IDLE, `mthi` and `mtlo` together with `wdata`=32'h1234_5678 -> `hi`=`lo`=32'h1234_5678 next cycle. Same inputs with `start`=1 -> move dropped, multiply issued.
5. `start` in the DONE cycle (back-to-back, `op`=01, `z`=64'd50 twice from zero) -> `busy` re-asserts with no IDLE gap; final `{hi,lo}`=64'd100; two `done` pulses.
6. `reset` asserted one cycle before the commit edge -> no commit; `hi`=`lo`=0, `busy`=0, `done`=0; a subsequent `start` completes normally.
